// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder (tag encodings, NOP word, issue select).
package mem_responder_pkg;

    localparam int unsigned WORD_OFF_W = 2;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

    typedef enum logic [1:0] {
        RESP_NONE  = 2'd0,
        RESP_FETCH = 2'd1,
        RESP_LOAD  = 2'd2
    } resp_tag_e;

    typedef enum logic [1:0] {
        ISSUE_NONE  = 2'd0,
        ISSUE_STORE = 2'd1,
        ISSUE_LOAD  = 2'd2,
        ISSUE_FETCH = 2'd3
    } issue_e;

endpackage

// File: rtl/mem_resp_arbiter.sv
// Store > load > fetch issue selection with a one-deep pending-fetch register.
module mem_resp_arbiter
    import mem_responder_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pc_clk,
    input  logic [W-1:0] pc,
    input  logic         d_ld,
    input  logic         d_st,
    output issue_e       sel_c,
    output logic [W-1:0] fetch_addr_c,
    output logic         overwrite_c
);

    logic         pend_valid;
    logic [W-1:0] pend_addr;
    logic         fetch_req_c;

    // A fresh strobe always wins over a stale pending address.
    always_comb begin
        fetch_req_c  = pc_clk | pend_valid;
        fetch_addr_c = pc_clk ? pc : pend_addr;
        overwrite_c  = pc_clk & pend_valid;
        sel_c        = ISSUE_NONE;
        if (d_st) begin
            sel_c = ISSUE_STORE;
        end else if (d_ld) begin
            sel_c = ISSUE_LOAD;
        end else if (fetch_req_c) begin
            sel_c = ISSUE_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
        end else if (fetch_req_c && (sel_c != ISSUE_FETCH)) begin
            pend_valid <= 1'b1;
            pend_addr  <= fetch_addr_c;
        end else if (sel_c == ISSUE_FETCH) begin
            pend_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates fetch/load/store onto one sync RAM and holds responses.
// Optional request counters enabled by defining MEM_RESP_STATS_EN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned W             = 32,
    parameter int unsigned RAM_AW        = 12,
    parameter logic [W-1:0] RESET_PC_WORD = W'(NOP_WORD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_clk,
    input  logic [W-1:0]      pc,
    input  logic              load_clk,
    input  logic              load_en,
    input  logic [W-1:0]      l_addr,
    input  logic              store_clk,
    input  logic              store_en,
    input  logic [W-1:0]      s_addr,
    input  logic [W-1:0]      s_data,
    output logic [W-1:0]      read_inst,
    output logic [W-1:0]      l_data,
    output logic              inst_valid,
    output logic              load_valid,
    output logic              err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [W-1:0]      ram_wdata,
`ifdef MEM_RESP_STATS_EN
    output logic [W-1:0]      stat_fetch,
    output logic [W-1:0]      stat_load,
    output logic [W-1:0]      stat_store,
`endif
    input  logic [W-1:0]      ram_rdata
);

    localparam int unsigned HI_SHIFT = RAM_AW + WORD_OFF_W;

    logic         d_ld_c;
    logic         d_st_c;
    issue_e       sel_c;
    logic [W-1:0] fetch_addr_c;
    logic         overwrite_c;

    logic [W-1:0]      req_addr_c;
    logic              misaligned_c;
    logic              oor_c;
    logic              ram_en_d_c;
    logic              ram_we_d_c;
    logic [RAM_AW-1:0] ram_addr_d_c;
    logic [W-1:0]      ram_wdata_d_c;
    resp_tag_e         tag_d_c;
    logic              err_set_c;
    logic [W-1:0]      rsp_data_c;

    resp_tag_e tag_iss;
    resp_tag_e tag_rsp;
    logic      zero_iss;
    logic      zero_rsp;

    assign d_ld_c = load_clk & load_en;
    assign d_st_c = store_clk & store_en;

    mem_resp_arbiter #(.W(W)) u_arb (
        .clk          (clk),
        .rst          (rst),
        .pc_clk       (pc_clk),
        .pc           (pc),
        .d_ld         (d_ld_c),
        .d_st         (d_st_c),
        .sel_c        (sel_c),
        .fetch_addr_c (fetch_addr_c),
        .overwrite_c  (overwrite_c)
    );

    // Decode the selected request into next-cycle RAM drive and response tag.
    always_comb begin
        req_addr_c    = '0;
        ram_wdata_d_c = '0;
        tag_d_c       = RESP_NONE;
        case (sel_c)
            ISSUE_STORE: begin
                req_addr_c    = s_addr;
                ram_wdata_d_c = s_data;
            end
            ISSUE_LOAD: begin
                req_addr_c = l_addr;
                tag_d_c    = RESP_LOAD;
            end
            ISSUE_FETCH: begin
                req_addr_c = fetch_addr_c;
                tag_d_c    = RESP_FETCH;
            end
            default: ;
        endcase
        misaligned_c  = |req_addr_c[WORD_OFF_W-1:0];
        oor_c         = |(req_addr_c >> HI_SHIFT);
        ram_en_d_c    = (sel_c != ISSUE_NONE) && !oor_c;
        ram_we_d_c    = (sel_c == ISSUE_STORE) && !oor_c;
        ram_addr_d_c  = req_addr_c[HI_SHIFT-1:WORD_OFF_W];
        err_set_c     = (d_ld_c & d_st_c) | overwrite_c
                      | ((sel_c != ISSUE_NONE) & (misaligned_c | oor_c));
        rsp_data_c    = zero_rsp ? '0 : ram_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            tag_iss    <= RESP_NONE;
            tag_rsp    <= RESP_NONE;
            zero_iss   <= 1'b0;
            zero_rsp   <= 1'b0;
            read_inst  <= RESET_PC_WORD;
            l_data     <= '0;
            inst_valid <= 1'b0;
            load_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            ram_en     <= ram_en_d_c;
            ram_we     <= ram_we_d_c;
            ram_addr   <= ram_addr_d_c;
            ram_wdata  <= ram_wdata_d_c;
            tag_iss    <= tag_d_c;
            zero_iss   <= oor_c;
            tag_rsp    <= tag_iss;
            zero_rsp   <= zero_iss;
            inst_valid <= (tag_rsp == RESP_FETCH);
            load_valid <= (tag_rsp == RESP_LOAD);
            if (tag_rsp == RESP_FETCH) begin
                read_inst <= rsp_data_c;
            end
            if (tag_rsp == RESP_LOAD) begin
                l_data <= rsp_data_c;
            end
            if (err_set_c) begin
                err <= 1'b1;
            end
        end
    end

`ifdef MEM_RESP_STATS_EN
    // Counts issued requests; suppressed stores never reach RAM and are not counted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_fetch <= '0;
            stat_load  <= '0;
            stat_store <= '0;
        end else begin
            if (sel_c == ISSUE_FETCH) begin
                stat_fetch <= stat_fetch + W'(1);
            end
            if (sel_c == ISSUE_LOAD) begin
                stat_load <= stat_load + W'(1);
            end
            if ((sel_c == ISSUE_STORE) && !oor_c) begin
                stat_store <= stat_store + W'(1);
            end
        end
    end
`endif

endmodule
